button_events_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel debounced one-shot.
- Each of N_CHANNELS raw button inputs is synchronised and debounced; the block then emits single-cycle press, release, long-press and optional auto-repeat event pulses, plus the debounced level.
- Sits between board push-buttons and the user FSMs and counters in the lab designs, replacing per-button one_shot instances.

---
 rtl/button_events_multi.sv | 175 +++++++++++++++++
 tb/tb_button_events_multi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_events_multi.sv
// button_events_multi
//
// Multi-channel push-button front end. Each channel synchronises its raw
// input, debounces it, and runs a small event FSM that emits single-cycle
// press, release, long-press and auto-repeat pulses.
//
// Ports:
//   clk            system clock
//   rst_a_p        asynchronous reset, active high
//   button_in      raw asynchronous button levels, one bit per channel
//   repeat_en      per-channel auto-repeat enable, sampled every cycle
//   level_out      debounced pressed level (1 = pressed)
//   press_pulse    1-cycle pulse on each debounced press
//   release_pulse  1-cycle pulse on each debounced release
//   long_pulse     1-cycle pulse once per hold after LONG_CYC cycles
//   repeat_pulse   1-cycle pulse every REP_CYC cycles while held in LONG
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RELEASED | button up, waiting for a debounced press
//   PRESSED  | button held, hold counter running toward LONG_CYC
//   LONG     | long press reached, repeat counter running when enabled

module button_events_multi #(
    parameter int  N_CHANNELS       = 4,
    parameter int  CLK_FREQ_HZ      = 50_000_000,
    parameter real DEBOUNCE_TIME_MS = 20.0,
    parameter real LONG_PRESS_MS    = 1000.0,
    parameter real REPEAT_MS        = 200.0,
    parameter bit  ACTIVE_LOW       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_a_p,
    input  logic [N_CHANNELS-1:0] button_in,
    input  logic [N_CHANNELS-1:0] repeat_en,
    output logic [N_CHANNELS-1:0] level_out,
    output logic [N_CHANNELS-1:0] press_pulse,
    output logic [N_CHANNELS-1:0] release_pulse,
    output logic [N_CHANNELS-1:0] long_pulse,
    output logic [N_CHANNELS-1:0] repeat_pulse
);

    localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int DEB_RAW    = int'(real'(CYC_PER_MS) * DEBOUNCE_TIME_MS);
    localparam int LONG_RAW   = int'(real'(CYC_PER_MS) * LONG_PRESS_MS);
    localparam int REP_RAW    = int'(real'(CYC_PER_MS) * REPEAT_MS);

    localparam int DEB_CYC  = (DEB_RAW  < 1) ? 1 : DEB_RAW;
    localparam int LONG_CYC = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int REP_CYC  = (REP_RAW  < 1) ? 1 : REP_RAW;

    localparam int DW = $clog2(DEB_CYC) + 1;
    localparam int HW = $clog2(LONG_CYC) + 1;
    localparam int RW = $clog2(REP_CYC) + 1;

    localparam logic [DW-1:0] DEB_TC  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_TC = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_TC  = RW'(REP_CYC - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } state_t;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        logic          raw;
        logic          s1;
        logic          s2;
        logic          deb;
        logic [DW-1:0] deb_cnt;
        state_t        state;
        logic [HW-1:0] hold_cnt;
        logic [RW-1:0] rep_cnt;
        logic          lvl_r;
        logic          press_r;
        logic          release_r;
        logic          long_r;
        logic          repeat_r;

        // Polarity is normalised before the synchroniser so everything
        // downstream sees 1 = pressed.
        assign raw = button_in[g] ^ ACTIVE_LOW;

        always_ff @(posedge clk or posedge rst_a_p) begin
            if (rst_a_p) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                deb     <= 1'b0;
                deb_cnt <= '0;
            end else begin
                s1 <= raw;
                s2 <= s1;
                if (s2 == deb) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_TC) begin
                    deb     <= ~deb;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        // The FSM registers level and pulses together from the debounced
        // level, so level_out and its press/release pulse change on the
        // same edge. A fall always takes priority over long/repeat.
        always_ff @(posedge clk or posedge rst_a_p) begin
            if (rst_a_p) begin
                state     <= RELEASED;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                lvl_r     <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (deb) begin
                            state    <= PRESSED;
                            lvl_r    <= 1'b1;
                            press_r  <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!deb) begin
                            state     <= RELEASED;
                            lvl_r     <= 1'b0;
                            release_r <= 1'b1;
                        end else if (hold_cnt == HOLD_TC) begin
                            state   <= LONG;
                            long_r  <= 1'b1;
                            rep_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!deb) begin
                            state     <= RELEASED;
                            lvl_r     <= 1'b0;
                            release_r <= 1'b1;
                        end else if (!repeat_en[g]) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_TC) begin
                            repeat_r <= 1'b1;
                            rep_cnt  <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        lvl_r <= 1'b0;
                    end
                endcase
            end
        end

        assign level_out[g]     = lvl_r;
        assign press_pulse[g]   = press_r;
        assign release_pulse[g] = release_r;
        assign long_pulse[g]    = long_r;
        assign repeat_pulse[g]  = repeat_r;
    end

endmodule

// File: tb/tb_button_events_multi.sv
// Testbench for button_events_multi: directed stimulus pushes expected
// events (cycle, channel, kind) into a queue; a negedge monitor matches
// every observed pulse against it and flags unexpected or missing events.
// Timing with DEB_CYC=4: a raw change applied after edge c produces its
// level/pulse change at edge c+7. Long = press+20, repeat every 8 in LONG.

module tb_button_events_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_a_p = 1'b1;
    logic [N-1:0] button_in = 4'b1111;
    logic [N-1:0] repeat_en = 4'b0000;
    logic [N-1:0] level_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] repeat_pulse;

    button_events_multi #(
        .N_CHANNELS      (N),
        .CLK_FREQ_HZ     (1_000_000),
        .DEBOUNCE_TIME_MS(0.004),
        .LONG_PRESS_MS   (0.020),
        .REPEAT_MS       (0.008),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk          (clk),
        .rst_a_p      (rst_a_p),
        .button_in    (button_in),
        .repeat_en    (repeat_en),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3;

    typedef struct {
        int t;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_LONG:    return "long";
            default:   return "repeat";
        endcase
    endfunction

    task automatic expect_ev(input int ch, input int kind, input int t);
        ev_t e;
        e.t    = t;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Advance to just after edge t (t must be ahead of the current cycle).
    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_level(input logic [N-1:0] want, input string name);
        @(negedge clk);
        total++;
        if (level_out !== want) begin
            bad++;
            $display("FAIL %s cycle %0d: level_out=%b expected=%b", name, cyc, level_out, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [5*N-1:0] all;
        @(negedge clk);
        all = {level_out, press_pulse, release_pulse, long_pulse, repeat_pulse};
        total++;
        if (all !== '0) begin
            bad++;
            $display("FAIL %s cycle %0d: outputs=%h expected=0", name, cyc, all);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [N-1:0] ev [4];
        int nhi;
        int idx;
        ev[K_PRESS]   = press_pulse;
        ev[K_RELEASE] = release_pulse;
        ev[K_LONG]    = long_pulse;
        ev[K_REPEAT]  = repeat_pulse;
        for (int ch = 0; ch < N; ch++) begin
            nhi = 0;
            for (int k = 0; k < 4; k++) begin
                if (ev[k][ch] === 1'b1) begin
                    nhi++;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (exp_q[i].t == cyc && exp_q[i].ch == ch && exp_q[i].kind == k)
                            idx = i;
                    total++;
                    if (idx >= 0) begin
                        exp_q.delete(idx);
                    end else begin
                        bad++;
                        $display("FAIL unexpected_%s ch%0d cycle %0d: pulse=1 expected=0",
                                 kname(k), ch, cyc);
                    end
                end
            end
            if (nhi > 0) begin
                total++;
                if (nhi > 1) begin
                    bad++;
                    $display("FAIL onehot ch%0d cycle %0d: pulses_high=%0d expected<=1", ch, cyc, nhi);
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].t <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_%s ch%0d cycle %0d: pulse=0 expected=1",
                         kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].t);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        // Reset with all buttons held
        at_cycle(1);
        check_all_zero("reset_hold");
        at_cycle(2);
        rst_a_p = 1'b0;
        for (int ch = 0; ch < N; ch++) expect_ev(ch, K_PRESS, 9);
        check_all_zero("reset_release");
        at_cycle(10);
        check_level(4'b1111, "level_after_reset");
        at_cycle(11);
        button_in = 4'b0000;
        for (int ch = 0; ch < N; ch++) expect_ev(ch, K_RELEASE, 18);
        at_cycle(20);
        check_level(4'b0000, "level_all_released");

        // Glitch rejection on ch0: 3 high, 1 low, 3 high, low
        at_cycle(25); button_in[0] = 1'b1;
        at_cycle(28); button_in[0] = 1'b0;
        at_cycle(29); button_in[0] = 1'b1;
        at_cycle(31);
        check_level(4'b0000, "glitch_mid");
        at_cycle(32); button_in[0] = 1'b0;
        at_cycle(40);
        check_level(4'b0000, "glitch_end");

        // Short press/release on ch1
        at_cycle(45); button_in[1] = 1'b1;
        expect_ev(1, K_PRESS, 52);
        at_cycle(53);
        check_level(4'b0010, "ch1_pressed");
        at_cycle(55); button_in[1] = 1'b0;
        expect_ev(1, K_RELEASE, 62);

        // Long press with repeat on ch2; last repeat collides with release
        at_cycle(70);
        repeat_en[2] = 1'b1;
        button_in[2] = 1'b1;
        expect_ev(2, K_PRESS, 77);
        expect_ev(2, K_LONG, 97);
        expect_ev(2, K_REPEAT, 105);
        expect_ev(2, K_REPEAT, 113);
        expect_ev(2, K_REPEAT, 121);
        expect_ev(2, K_REPEAT, 129);
        at_cycle(100);
        check_level(4'b0100, "ch2_long_level");
        at_cycle(130); button_in[2] = 1'b0;
        expect_ev(2, K_RELEASE, 137);
        at_cycle(140);
        check_level(4'b0000, "ch2_released");

        // ch3 long with repeat disabled, then enabled mid-LONG
        at_cycle(145); button_in[3] = 1'b1;
        expect_ev(3, K_PRESS, 152);
        expect_ev(3, K_LONG, 172);
        at_cycle(185); repeat_en[3] = 1'b1;
        expect_ev(3, K_REPEAT, 193);
        expect_ev(3, K_REPEAT, 201);
        expect_ev(3, K_REPEAT, 209);
        at_cycle(205); button_in[3] = 1'b0;
        expect_ev(3, K_RELEASE, 212);

        // Mid-LONG reset on ch2 with ch0 activity alongside
        at_cycle(220); button_in[2] = 1'b1;
        expect_ev(2, K_PRESS, 227);
        expect_ev(2, K_LONG, 247);
        at_cycle(230); button_in[0] = 1'b1;
        expect_ev(0, K_PRESS, 237);
        at_cycle(240); button_in[0] = 1'b0;
        expect_ev(0, K_RELEASE, 247);
        at_cycle(250); rst_a_p = 1'b1;
        check_all_zero("mid_reset");
        at_cycle(252); rst_a_p = 1'b0;
        expect_ev(2, K_PRESS, 259);
        expect_ev(2, K_LONG, 279);
        expect_ev(2, K_REPEAT, 287);
        expect_ev(2, K_REPEAT, 295);
        at_cycle(254); button_in[0] = 1'b1;
        expect_ev(0, K_PRESS, 261);
        at_cycle(262);
        check_level(4'b0101, "after_mid_reset");
        at_cycle(264); button_in[0] = 1'b0;
        expect_ev(0, K_RELEASE, 271);
        at_cycle(290); button_in[2] = 1'b0;
        expect_ev(2, K_RELEASE, 297);
        at_cycle(305);
        check_level(4'b0000, "final_level");
        at_cycle(310);

        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            bad++;
            $display("FAIL missing_%s ch%0d cycle %0d: pulse=0 expected=1",
                     kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
